// File: rtl/aes_round_sched.sv
// ============================================================================
//  Module      : aes_round_sched
//  Description : AES encryption sequencer. Ensures a cached key schedule,
//                then steps the round datapath through AddRoundKey, the
//                middle rounds and the final round.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_sched #(
    parameter int NUM_ROUNDS  = 10,
    parameter int KEY_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       new_key,
    input  logic       key_done,
    output logic       key_enable,
    output logic       round_en,
    output logic       add_key_only,
    output logic       skip_mix,
    output logic [3:0] round_num,
    output logic       busy,
    output logic       done,
    output logic       key_err
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_KEY_GEN = 3'd1;
    localparam logic [2:0] c_INIT    = 3'd2;
    localparam logic [2:0] c_ROUND   = 3'd3;
    localparam logic [2:0] c_FINAL   = 3'd4;
    localparam logic [2:0] c_DONE    = 3'd5;
    localparam logic [2:0] c_ERR     = 3'd6;

    localparam logic [3:0] c_LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [3:0] c_LAST_MID   = 4'(NUM_ROUNDS - 1);
    localparam logic [8:0] c_TIMEOUT    = 9'(KEY_TIMEOUT);

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [3:0] r_round;
    logic [3:0] w_round_next;
    logic [7:0] r_tmo;
    logic [7:0] w_tmo_next;
    logic [8:0] w_tmo_inc;
    logic       r_key_valid;
    logic       r_key_dirty;

    assign w_tmo_inc = {1'b0, r_tmo} + 9'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_round <= 4'd0;
            r_tmo   <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_round <= w_round_next;
            r_tmo   <= w_tmo_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_round_next = r_round;
        w_tmo_next   = r_tmo;
        case (r_state)
            c_IDLE: begin
                w_tmo_next = 8'd0;
                if (start) begin
                    w_next_state = r_key_valid ? c_INIT : c_KEY_GEN;
                    // Preload round 0 so INIT presents it straight away.
                    if (r_key_valid) begin
                        w_round_next = 4'd0;
                    end
                end
            end
            c_KEY_GEN: begin
                w_tmo_next = w_tmo_inc[7:0];
                // A late key_done still wins over the timeout.
                if (key_done) begin
                    w_next_state = c_INIT;
                    w_round_next = 4'd0;
                end else if (w_tmo_inc == c_TIMEOUT) begin
                    w_next_state = c_ERR;
                end
            end
            c_INIT: begin
                w_next_state = c_ROUND;
                w_round_next = 4'd1;
            end
            c_ROUND: begin
                if (r_round == c_LAST_MID) begin
                    w_next_state = c_FINAL;
                    w_round_next = c_LAST_ROUND;
                end else begin
                    w_round_next = r_round + 4'd1;
                end
            end
            c_FINAL: begin
                w_next_state = c_DONE;
            end
            c_DONE: begin
                w_next_state = c_IDLE;
            end
            c_ERR: begin
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // A rewrite seen at any point of generation poisons the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_dirty <= 1'b0;
        end else if (r_state == c_IDLE) begin
            r_key_dirty <= 1'b0;
        end else if ((r_state == c_KEY_GEN) && new_key) begin
            r_key_dirty <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_valid <= 1'b0;
        end else if (new_key) begin
            r_key_valid <= 1'b0;
        end else if ((r_state == c_KEY_GEN) && key_done && !r_key_dirty) begin
            r_key_valid <= 1'b1;
        end
    end

    assign key_enable   = (r_state == c_KEY_GEN);
    assign round_en     = (r_state == c_INIT) || (r_state == c_ROUND) || (r_state == c_FINAL);
    assign add_key_only = (r_state == c_INIT);
    assign skip_mix     = (r_state == c_FINAL);
    assign round_num    = r_round;
    assign busy         = (r_state != c_IDLE);
    assign done         = (r_state == c_DONE);
    assign key_err      = (r_state == c_ERR);

endmodule

`default_nettype wire

// File: tb/tb_aes_round_sched.sv
// ============================================================================
//  Module      : tb_aes_round_sched
//  Description : Self-checking bench for aes_round_sched (table vectors,
//                hand-written corner sequences and randomized blocks).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_round_sched;

    localparam int c_NR = 10;
    localparam int c_KT = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       new_key = 1'b0;
    logic       key_done = 1'b0;
    logic       key_enable;
    logic       round_en;
    logic       add_key_only;
    logic       skip_mix;
    logic [3:0] round_num;
    logic       busy;
    logic       done;
    logic       key_err;

    int total = 0;
    int bad = 0;
    bit model_valid = 1'b0;

    typedef struct {
        int k;
        int nk_at;
        int st_at;
        int e_lat;
        int e_ken;
        int e_err;
        int e_ren;
    } vec_t;

    vec_t tbl [8];

    aes_round_sched #(
        .NUM_ROUNDS (c_NR),
        .KEY_TIMEOUT(c_KT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .new_key     (new_key),
        .key_done    (key_done),
        .key_enable  (key_enable),
        .round_en    (round_en),
        .add_key_only(add_key_only),
        .skip_mix    (skip_mix),
        .round_num   (round_num),
        .busy        (busy),
        .done        (done),
        .key_err     (key_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts one block in the current (idle) cycle and follows it to done/key_err.
    task automatic run_block(input int k, input int nk_at, input int st_at,
                             output int lat, output int ken, output int err,
                             output int ren, output int seq_ok);
        int prev_ren;
        lat = -1; ken = 0; err = 0; ren = 0; seq_ok = 1; prev_ren = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            key_done = 1'b0;
            new_key  = (c == nk_at);
            start    = (c == st_at);
            if (busy !== 1'b1) seq_ok = 0;
            if (key_enable) begin
                ken++;
                if (ken == k) key_done = 1'b1;
            end
            if (round_en) begin
                if (round_num != 4'(ren) || add_key_only != (ren == 0) || skip_mix != (ren == c_NR))
                    seq_ok = 0;
                if (ren > 0 && prev_ren == 0) seq_ok = 0;
                ren++;
            end else if (add_key_only || skip_mix) begin
                seq_ok = 0;
            end
            prev_ren = int'(round_en);
            if (key_err) err++;
            if (done || key_err) begin
                lat = c;
                break;
            end
            step();
        end
        key_done = 1'b0;
        new_key  = 1'b0;
        start    = 1'b0;
        step();
        check("post_idle", int'({busy, done, key_err, round_en, key_enable}), 0);
        if (err == 0 && lat > 0) check("hold_round_num", int'(round_num), c_NR);
    endtask

    task automatic do_block(input string name, input int k, input int nk_at, input int st_at,
                            input int e_lat, input int e_ken, input int e_err, input int e_ren);
        int lat, ken, err, ren, seq_ok;
        run_block(k, nk_at, st_at, lat, ken, err, ren, seq_ok);
        check({name, "_latency"}, lat, e_lat);
        check({name, "_key_enable_cycles"}, ken, e_ken);
        check({name, "_key_err"}, err, e_err);
        check({name, "_round_cycles"}, ren, e_ren);
        check({name, "_sequence"}, seq_ok, 1);
        model_valid = (e_err == 0) && (nk_at == 0);
    endtask

    // Block-level expectation from the cached flag and key-timer delay.
    task automatic predict(input int k, output int lat, output int ken,
                           output int err, output int ren);
        if (model_valid) begin
            lat = c_NR + 2; ken = 0; err = 0; ren = c_NR + 1;
        end else if (k >= 1 && k <= c_KT) begin
            lat = k + c_NR + 2; ken = k; err = 0; ren = c_NR + 1;
        end else begin
            lat = c_KT + 1; ken = c_KT; err = 1; ren = 0;
        end
    endtask

    initial begin
        int found;
        int ken;
        int e_lat, e_ken, e_err, e_ren, k, nk_at, st_at;

        //          k  nk st  lat ken err ren
        tbl[0] = '{ 8, 0, 0, 20,  8, 0, 11};
        tbl[1] = '{ 8, 0, 0, 12,  0, 0, 11};
        tbl[2] = '{ 8, 6, 4, 12,  0, 0, 11};
        tbl[3] = '{ 3, 2, 0, 15,  3, 0, 11};
        tbl[4] = '{ 1, 1, 0, 13,  1, 0, 11};
        tbl[5] = '{ 0, 0, 5, 33, 32, 1,  0};
        tbl[6] = '{32, 0, 0, 44, 32, 0, 11};
        tbl[7] = '{ 5, 0, 0, 12,  0, 0, 11};

        rst = 1'b1;
        repeat (2) step();
        check("reset_outputs", int'({key_enable, round_en, add_key_only, skip_mix, busy, done, key_err}), 0);
        check("reset_round_num", int'(round_num), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++)
            do_block($sformatf("vec%0d", i), tbl[i].k, tbl[i].nk_at, tbl[i].st_at,
                     tbl[i].e_lat, tbl[i].e_ken, tbl[i].e_err, tbl[i].e_ren);

        // Reset in the middle of round 4.
        found = 0;
        ken = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            key_done = 1'b0;
            if (key_enable) begin
                ken++;
                if (ken == 2) key_done = 1'b1;
            end
            if (round_en && round_num == 4'd4) begin
                found = 1;
                break;
            end
            step();
        end
        key_done = 1'b0;
        check("reached_round4", found, 1);
        rst = 1'b1;
        #1;
        check("midrst_outputs", int'({key_enable, round_en, add_key_only, skip_mix, busy, done, key_err}), 0);
        check("midrst_round_num", int'(round_num), 0);
        step();
        rst = 1'b0;
        model_valid = 1'b0;
        step();
        do_block("after_rst", 5, 0, 0, 17, 5, 0, 11);

        for (int n = 0; n < 20; n++) begin
            k = int'($urandom_range(0, 40));
            predict(k, e_lat, e_ken, e_err, e_ren);
            nk_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, e_lat - 1)) : 0;
            st_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, e_lat - 1)) : 0;
            do_block($sformatf("rand%0d", n), k, nk_at, st_at, e_lat, e_ken, e_err, e_ren);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
